// File: rtl/dm9000a_bus_ctrl.sv
// rtl/dm9000a_bus_ctrl.sv - DM9000A asynchronous bus cycle generator with reset sequencing and interrupt sync
// Optional macro DM9K_IRQ_LATCH_EN: latch oINT on rising edge of ENET_INT until iINT_CLR.
module dm9000a_bus_ctrl #(
  parameter int DATA_W     = 16,
  parameter int T_SETUP    = 1,
  parameter int T_PULSE    = 2,
  parameter int T_HOLD     = 1,
  parameter int RST_CYCLES = 1000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic              iREQ,
  input  logic              iWE,
  input  logic              iCMD,
  input  logic [DATA_W-1:0] iWDATA,
  output logic [DATA_W-1:0] oRDATA,
  output logic              oACK,
  output logic              oBUSY,
  output logic              oREADY,
  input  logic              iINT_CLR,
  output logic              oINT,
  inout  wire  [DATA_W-1:0] ENET_DATA,
  output logic              ENET_CMD,
  output logic              ENET_CS_N,
  output logic              ENET_RD_N,
  output logic              ENET_WR_N,
  output logic              ENET_RST_N,
  input  logic              ENET_INT
);

  localparam int MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int MAX_SPH = (MAX_SP > T_HOLD) ? MAX_SP : T_HOLD;
  localparam int MAXV = (MAX_SPH > RST_CYCLES) ? MAX_SPH : RST_CYCLES;
  localparam int CW = (MAXV > 1) ? $clog2(MAXV) : 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = (T_HOLD > 0) ? CW'(T_HOLD - 1) : '0;
  localparam logic [CW-1:0] LD_RST   = CW'(RST_CYCLES - 1);

  generate
    if (!(DATA_W == 8 || DATA_W == 16 || DATA_W == 32)) begin : g_bad_data_w
      $error("dm9000a_bus_ctrl: DATA_W must be 8, 16 or 32");
    end
    if (T_SETUP < 1 || T_PULSE < 1 || T_HOLD < 0 || RST_CYCLES < 1) begin : g_bad_timing
      $error("dm9000a_bus_ctrl: timing parameter below minimum");
    end
  endgenerate

  typedef enum logic [2:0] {
    RST_WAIT = 3'd0,
    IDLE     = 3'd1,
    SETUP    = 3'd2,
    PULSE    = 3'd3,
    HOLD     = 3'd4
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic              data_oe;
  logic [DATA_W-1:0] wdata_q;

  // Only the output-enable gates the bus; its async reset releases the bus at once.
  assign ENET_DATA = data_oe ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state      <= RST_WAIT;
      cnt        <= LD_RST;
      we_q       <= 1'b0;
      data_oe    <= 1'b0;
      wdata_q    <= '0;
      oRDATA     <= '0;
      oACK       <= 1'b0;
      oBUSY      <= 1'b1;
      oREADY     <= 1'b0;
      ENET_CMD   <= 1'b0;
      ENET_CS_N  <= 1'b1;
      ENET_RD_N  <= 1'b1;
      ENET_WR_N  <= 1'b1;
      ENET_RST_N <= 1'b0;
    end else begin
      oACK <= 1'b0;
      case (state)
        RST_WAIT: begin
          if (cnt == '0) begin
            state      <= IDLE;
            ENET_RST_N <= 1'b1;
            oREADY     <= 1'b1;
            oBUSY      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        IDLE: begin
          if (iREQ) begin
            state     <= SETUP;
            cnt       <= LD_SETUP;
            we_q      <= iWE;
            wdata_q   <= iWDATA;
            ENET_CMD  <= iCMD;
            ENET_CS_N <= 1'b0;
            oBUSY     <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state     <= PULSE;
            cnt       <= LD_PULSE;
            ENET_RD_N <= we_q;
            ENET_WR_N <= !we_q;
            data_oe   <= we_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            ENET_RD_N <= 1'b1;
            ENET_WR_N <= 1'b1;
            if (!we_q) begin
              oRDATA <= ENET_DATA;
            end
            if (T_HOLD == 0) begin
              state     <= IDLE;
              ENET_CS_N <= 1'b1;
              ENET_CMD  <= 1'b0;
              data_oe   <= 1'b0;
              oACK      <= 1'b1;
              oBUSY     <= 1'b0;
            end else begin
              state <= HOLD;
              cnt   <= LD_HOLD;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state     <= IDLE;
            ENET_CS_N <= 1'b1;
            ENET_CMD  <= 1'b0;
            data_oe   <= 1'b0;
            oACK      <= 1'b1;
            oBUSY     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ENET_CS_N <= 1'b1;
          ENET_RD_N <= 1'b1;
          ENET_WR_N <= 1'b1;
          data_oe   <= 1'b0;
          oBUSY     <= 1'b0;
        end
      endcase
    end
  end

  logic int_s1;
  logic int_s2;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      int_s1 <= 1'b0;
      int_s2 <= 1'b0;
    end else begin
      int_s1 <= ENET_INT;
      int_s2 <= int_s1;
    end
  end

`ifdef DM9K_IRQ_LATCH_EN
  logic int_s3;

  // A new edge beats a coincident clear so no interrupt is lost.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      int_s3 <= 1'b0;
      oINT   <= 1'b0;
    end else begin
      int_s3 <= int_s2;
      if (int_s2 && !int_s3) begin
        oINT <= 1'b1;
      end else if (iINT_CLR) begin
        oINT <= 1'b0;
      end
    end
  end
`else
  logic unused_int_clr;

  assign unused_int_clr = iINT_CLR;
  assign oINT = int_s2;
`endif

endmodule

// File: tb/tb_dm9000a_bus_ctrl.sv
// tb/tb_dm9000a_bus_ctrl.sv - scoreboard bench for dm9000a_bus_ctrl (default and T_HOLD=0 instances)
module tb_dm9000a_bus_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic        req_a = 0, we_a = 0, cmd_a = 0, int_clr_a = 0, enet_int_a = 0;
  logic [15:0] wdata_a = '0, rdata_a, dev_a = '0;
  logic        ack_a, busy_a, ready_a, int_a;
  logic        ecmd_a, cs_n_a, rd_n_a, wr_n_a, erst_n_a;
  wire  [15:0] data_a;

  logic        req_b = 0, we_b = 0, cmd_b = 0, int_clr_b = 0, enet_int_b = 0;
  logic [15:0] wdata_b = '0, rdata_b, dev_b = '0;
  logic        ack_b, busy_b, ready_b, int_b;
  logic        ecmd_b, cs_n_b, rd_n_b, wr_n_b, erst_n_b;
  wire  [15:0] data_b;

  // Device models drive read data while RD_N is low; idle bus floats high.
  assign data_a = !rd_n_a ? dev_a : 16'hzzzz;
  assign data_b = !rd_n_b ? dev_b : 16'hzzzz;
  pullup pu_a (data_a);
  pullup pu_b (data_b);

  dm9000a_bus_ctrl #(.RST_CYCLES(8)) u_dut_a (
    .iCLK(clk), .iRST_N(rst_n), .iREQ(req_a), .iWE(we_a), .iCMD(cmd_a),
    .iWDATA(wdata_a), .oRDATA(rdata_a), .oACK(ack_a), .oBUSY(busy_a),
    .oREADY(ready_a), .iINT_CLR(int_clr_a), .oINT(int_a), .ENET_DATA(data_a),
    .ENET_CMD(ecmd_a), .ENET_CS_N(cs_n_a), .ENET_RD_N(rd_n_a),
    .ENET_WR_N(wr_n_a), .ENET_RST_N(erst_n_a), .ENET_INT(enet_int_a)
  );

  dm9000a_bus_ctrl #(.T_HOLD(0), .RST_CYCLES(8)) u_dut_b (
    .iCLK(clk), .iRST_N(rst_n), .iREQ(req_b), .iWE(we_b), .iCMD(cmd_b),
    .iWDATA(wdata_b), .oRDATA(rdata_b), .oACK(ack_b), .oBUSY(busy_b),
    .oREADY(ready_b), .iINT_CLR(int_clr_b), .oINT(int_b), .ENET_DATA(data_b),
    .ENET_CMD(ecmd_b), .ENET_CS_N(cs_n_b), .ENET_RD_N(rd_n_b),
    .ENET_WR_N(wr_n_b), .ENET_RST_N(erst_n_b), .ENET_INT(enet_int_b)
  );

  typedef struct {
    logic        rd;
    logic [15:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (ack_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("ack_a_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("ack_a_cycle", cyc, e.cyc);
        if (e.rd) chk("rdata_a", rdata_a, e.rdata);
      end
    end
  end

  always @(negedge clk) begin
    if (ack_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("ack_b_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("ack_b_cycle", cyc, e.cyc);
        if (e.rd) chk("rdata_b", rdata_b, e.rdata);
      end
    end
  end

  task automatic wait_idle_a();
    int n;
    n = 0;
    @(negedge clk);
    while (busy_a !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_a_wait", busy_a, 0);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 7) begin
        req_a = 0;
        req_b = 0;
      end
    end while (erst_n_a !== 1'b1 && n < 40);
    chk({name, "_rst_low_edges"}, n, 8);
    chk({name, "_ready_a"}, ready_a, 1);
    chk({name, "_busy_a"}, busy_a, 0);
    chk({name, "_rst_n_b"}, erst_n_b, 1);
  endtask

  task automatic xfer_a(input logic we, input logic cmd, input logic [15:0] wd, input logic [15:0] dv);
    int a, cs_lo, rd_lo, wr_lo;
    logic [15:0] exp_bus;
    cs_lo = 0; rd_lo = 0; wr_lo = 0;
    wait_idle_a();
    we_a = we; cmd_a = cmd; wdata_a = wd; dev_a = dv; req_a = 1;
    @(posedge clk);
    #1;
    a = cyc;
    req_a = 0;
    q_a.push_back('{rd: !we, rdata: dv, cyc: a + 4});
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      cs_lo += int'(!cs_n_a);
      rd_lo += int'(!rd_n_a);
      wr_lo += int'(!wr_n_a);
      exp_bus = 16'hFFFF;
      if (we && j >= 1 && j <= 3) exp_bus = wd;
      if (!we && j >= 1 && j <= 2) exp_bus = dv;
      chk($sformatf("bus_a_j%0d", j), data_a, exp_bus);
      if (j < 4) chk($sformatf("cmd_a_j%0d", j), ecmd_a, cmd);
    end
    chk("cs_low_cycles", cs_lo, 4);
    chk("wr_low_cycles", wr_lo, we ? 2 : 0);
    chk("rd_low_cycles", rd_lo, we ? 0 : 2);
  endtask

  initial begin
    int a, n, rd_lo;
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_cs_n", cs_n_a, 1);
    chk("rst_rd_n", rd_n_a, 1);
    chk("rst_wr_n", wr_n_a, 1);
    chk("rst_cmd", ecmd_a, 0);
    chk("rst_enet_rst_n", erst_n_a, 0);
    chk("rst_bus", data_a, 16'hFFFF);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_ack", ack_a, 0);
    chk("rst_busy", busy_a, 1);
    chk("rst_ready", ready_a, 0);
    chk("rst_int", int_a, 0);

    // Release with requests pending on both instances; none may be acknowledged.
    rst_n = 1;
    we_a = 1; req_a = 1; we_b = 1; req_b = 1;
    wait_ready("release");

    xfer_a(1'b1, 1'b1, 16'hA55A, 16'h0000);
    xfer_a(1'b0, 1'b1, 16'h0000, 16'h1234);
    xfer_a(1'b1, 1'b0, 16'h00FF, 16'h0000);
    xfer_a(1'b0, 1'b0, 16'h0000, 16'hBEEF);

    // Back-to-back reads on the T_HOLD=0 instance with iREQ held high.
    n = 0;
    while (busy_b !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_b_wait", busy_b, 0);
    we_b = 0; cmd_b = 1; dev_b = 16'hC3C3; req_b = 1;
    @(posedge clk);
    #1;
    a = cyc;
    q_b.push_back('{rd: 1'b1, rdata: 16'hC3C3, cyc: a + 3});
    q_b.push_back('{rd: 1'b1, rdata: 16'h0F0F, cyc: a + 7});
    q_b.push_back('{rd: 1'b1, rdata: 16'hF00F, cyc: a + 11});
    rd_lo = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      rd_lo += int'(!rd_n_b);
      chk($sformatf("b2b_cs_n_j%0d", j), cs_n_b, (j % 4 == 3) ? 1 : 0);
      if (j == 3) begin
        chk("b2b_busy_in_ack", busy_b, 0);
        dev_b = 16'h0F0F;
      end
      if (j == 7) dev_b = 16'hF00F;
      if (j == 9) req_b = 0;
    end
    chk("b2b_rd_low_cycles", rd_lo, 6);
    chk("b2b_wr_n", wr_n_b, 1);

    // Reset asserted in the middle of a write strobe.
    wait_idle_a();
    we_a = 1; cmd_a = 1; wdata_a = 16'h0000; req_a = 1;
    @(posedge clk);
    #1 req_a = 0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_wr_active", wr_n_a, 0);
    rst_n = 0;
    #1;
    chk("abort_wr_n", wr_n_a, 1);
    chk("abort_rd_n", rd_n_a, 1);
    chk("abort_cs_n", cs_n_a, 1);
    chk("abort_bus", data_a, 16'hFFFF);
    chk("abort_busy", busy_a, 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    wait_ready("abort");
    xfer_a(1'b0, 1'b1, 16'h0000, 16'h8001);

`ifdef DM9K_IRQ_LATCH_EN
    @(negedge clk) enet_int_a = 1;
    @(negedge clk) enet_int_a = 0;
    chk("irq_e1", int_a, 0);
    @(negedge clk) chk("irq_e2", int_a, 0);
    @(negedge clk) chk("irq_e3", int_a, 1);
    repeat (3) @(negedge clk);
    chk("irq_held", int_a, 1);
    enet_int_a = 1;
    @(negedge clk) enet_int_a = 0;
    @(negedge clk) int_clr_a = 1;
    @(negedge clk) int_clr_a = 0;
    chk("irq_set_wins", int_a, 1);
    int_clr_a = 1;
    @(negedge clk) int_clr_a = 0;
    chk("irq_cleared", int_a, 0);
    @(negedge clk) chk("irq_stays_clear", int_a, 0);
`else
    @(negedge clk) enet_int_a = 1;
    @(negedge clk) chk("irq_lvl_e1", int_a, 0);
    @(negedge clk) chk("irq_lvl_e2", int_a, 1);
    int_clr_a = 1;
    @(negedge clk) chk("irq_lvl_clr_ignored", int_a, 1);
    int_clr_a = 0;
    enet_int_a = 0;
    @(negedge clk) chk("irq_lvl_fall_e1", int_a, 1);
    @(negedge clk) chk("irq_lvl_fall_e2", int_a, 0);
`endif

    repeat (4) @(negedge clk);
    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
